core_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the execute stage's operand-select and the instruction, data-memory and register-file strobes, and owns the PC register. It also counts retired instructions and halts into a sticky trap state on illegal instructions, memory timeouts or misaligned PC targets.

---
 rtl/core_ctrl_fsm_if.sv | 24 ++
 rtl/core_ctrl_fsm.sv | 180 ++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_fsm_if.sv
// Memory handshake bundle between the control sequencer and the instruction/data memories.
interface core_ctrl_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with PC, retire counter and a
// sticky trap state for illegal instructions, memory timeouts and misaligned PC targets.
module core_ctrl_fsm #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    core_ctrl_fsm_if.master      mem_io,
    output logic                 ir_we_o,
    input  logic                 is_load_i,
    input  logic                 is_store_i,
    input  logic                 is_branch_i,
    input  logic                 is_jal_i,
    input  logic                 is_jalr_i,
    input  logic                 is_lui_i,
    input  logic                 is_auipc_i,
    input  logic                 is_imm_i,
    input  logic                 illegal_i,
    output logic [1:0]           op_sel_o,
    input  logic [31:0]          next_pc_i,
    output logic [31:0]          pc_o,
    output logic                 rf_we_o,
    output logic                 wb_sel_o,
    output logic [31:0]          instret_o,
    output logic                 halted_o,
    output logic [2:0]           trap_cause_o
);
    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [2:0] CauseNone     = 3'd0;
    localparam logic [2:0] CauseImem     = 3'd1;
    localparam logic [2:0] CauseIllegal  = 3'd2;
    localparam logic [2:0] CauseDmem     = 3'd3;
    localparam logic [2:0] CauseMisalign = 3'd4;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instret_q, instret_d;
    logic [2:0]        cause_q, cause_d;
    logic [CntW-1:0]   wait_q, wait_d;
    logic [1:0]        op_sel_q, op_sel_d;
    logic              load_q, load_d;
    logic              store_q, store_d;
    logic              branch_q, branch_d;

    logic wait_last;
    logic target_ok;

    // Last permitted wait cycle: no ack now means the timeout fires.
    assign wait_last = (MEM_TIMEOUT != 0) && (wait_q == CntW'(MEM_TIMEOUT - 1));
    assign target_ok = (next_pc_i[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            cause_q   <= CauseNone;
            wait_q    <= '0;
            op_sel_q  <= 2'b00;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            branch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
            op_sel_q  <= op_sel_d;
            load_q    <= load_d;
            store_q   <= store_d;
            branch_q  <= branch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        cause_d   = cause_q;
        wait_d    = wait_q;
        op_sel_d  = op_sel_q;
        load_d    = load_q;
        store_d   = store_q;
        branch_d  = branch_q;
        case (state_q)
            StFetch: begin
                if (mem_io.imem_ack) begin
                    state_d = StDecode;
                end else if (wait_last) begin
                    state_d = StTrap;
                    cause_d = CauseImem;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StDecode: begin
                // Latch the instruction class so later stages decode from registered state.
                load_d   = is_load_i;
                store_d  = is_store_i;
                branch_d = is_branch_i;
                if (is_jal_i || is_auipc_i) begin
                    op_sel_d = 2'b11;
                end else if (is_jalr_i || is_lui_i || is_load_i || is_store_i || is_imm_i) begin
                    op_sel_d = 2'b10;
                end else begin
                    op_sel_d = 2'b00;
                end
                if (illegal_i) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (load_q || store_q) begin
                    state_d = StMem;
                    wait_d  = '0;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (mem_io.dmem_ack) begin
                    if (!store_q) begin
                        state_d = StWb;
                    end else if (target_ok) begin
                        pc_d      = next_pc_i;
                        instret_d = instret_q + 32'd1;
                        wait_d    = '0;
                        state_d   = StFetch;
                    end else begin
                        state_d = StTrap;
                        cause_d = CauseMisalign;
                    end
                end else if (wait_last) begin
                    state_d = StTrap;
                    cause_d = CauseDmem;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StWb: begin
                if (target_ok) begin
                    pc_d      = next_pc_i;
                    instret_d = instret_q + 32'd1;
                    wait_d    = '0;
                    state_d   = StFetch;
                end else begin
                    state_d = StTrap;
                    cause_d = CauseMisalign;
                end
            end
            default: state_d = StTrap;
        endcase
    end

    always_comb begin
        // FETCH is the reset state, so its strobes are gated off while reset is held.
        mem_io.imem_req = (state_q == StFetch) && rst_ni;
        ir_we_o         = (state_q == StFetch) && rst_ni && mem_io.imem_ack;
        mem_io.dmem_req = (state_q == StMem);
        mem_io.dmem_we  = (state_q == StMem) && store_q;
        rf_we_o         = (state_q == StWb) && !branch_q && !store_q && target_ok;
        wb_sel_o        = (state_q == StWb) && load_q;
        op_sel_o        = 2'b00;
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            op_sel_o = op_sel_q;
        end
        halted_o     = (state_q == StTrap);
        pc_o         = pc_q;
        instret_o    = instret_q;
        trap_cause_o = cause_q;
    end
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed and randomized bench for core_ctrl_fsm against an instruction-level reference model.
module tb_core_ctrl_fsm;
    localparam logic [31:0] RstPc = 32'h0000_0100;
    localparam int          Tmo   = 16;

    typedef enum int {KAlu, KImm, KLui, KAuipc, KJal, KJalr, KBr, KLoad, KStore} kind_e;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_we;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_imm;
    logic        illegal;
    logic [1:0]  op_sel;
    logic [31:0] next_pc, pc, instret;
    logic        rf_we, wb_sel, halted;
    logic [2:0]  cause;

    always #5 clk = ~clk;

    core_ctrl_fsm_if mem_if ();

    core_ctrl_fsm #(
        .RESET_PC    (RstPc),
        .MEM_TIMEOUT (Tmo)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_io       (mem_if),
        .ir_we_o      (ir_we),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .is_branch_i  (is_branch),
        .is_jal_i     (is_jal),
        .is_jalr_i    (is_jalr),
        .is_lui_i     (is_lui),
        .is_auipc_i   (is_auipc),
        .is_imm_i     (is_imm),
        .illegal_i    (illegal),
        .op_sel_o     (op_sel),
        .next_pc_i    (next_pc),
        .pc_o         (pc),
        .rf_we_o      (rf_we),
        .wb_sel_o     (wb_sel),
        .instret_o    (instret),
        .halted_o     (halted),
        .trap_cause_o (cause)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural view of the model: only what an instruction stream makes visible.
    logic [31:0] m_pc, m_instret;
    logic        m_halt;
    logic [2:0]  m_cause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_op_sel(input kind_e k);
        case (k)
            KJal, KAuipc:                      return 2'b11;
            KJalr, KLui, KLoad, KStore, KImm:  return 2'b10;
            default:                           return 2'b00;
        endcase
    endfunction

    task automatic set_flags(input kind_e k, input logic ill);
        is_load   = (k == KLoad);
        is_store  = (k == KStore);
        is_branch = (k == KBr);
        is_jal    = (k == KJal);
        is_jalr   = (k == KJalr);
        is_lui    = (k == KLui);
        is_auipc  = (k == KAuipc);
        is_imm    = (k == KImm);
        illegal   = ill;
    endtask

    task automatic clear_flags();
        {is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_imm} = '0;
        illegal = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One cycle comparing the architectural state against the model.
    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".instret"}, instret, m_instret);
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
        chk({tag, ".cause"}, 32'(cause), 32'(m_cause));
        chk({tag, ".imem_req"}, 32'(mem_if.imem_req), 32'(!m_halt));
        chk({tag, ".dmem_req"}, 32'(mem_if.dmem_req), 32'd0);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'd0);
        adv();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        clear_flags();
        #1;
        chk("rst.pc", pc, RstPc);
        chk("rst.instret", instret, 32'd0);
        chk("rst.cause", 32'(cause), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.strobes", 32'({mem_if.imem_req, ir_we, mem_if.dmem_req, mem_if.dmem_we, rf_we}),
            32'd0);
        chk("rst.sel", 32'({op_sel, wb_sel}), 32'd0);
        @(posedge clk);
        adv();
        rst_n     = 1'b1;
        m_pc      = RstPc;
        m_instret = '0;
        m_halt    = 1'b0;
        m_cause   = 3'd0;
    endtask

    // Runs one instruction; fwait/mwait are ack-less cycles before the ack (>= Tmo: timeout).
    task automatic run_instr(input kind_e k, input int fwait, input int mwait,
                             input logic [31:0] npc, input logic ill);
        logic mem_op;
        logic aligned;
        mem_op  = (k == KLoad) || (k == KStore);
        aligned = (npc[1:0] == 2'b00);
        clear_flags();
        mem_if.imem_ack = 1'b0;
        for (int i = 0; i < fwait && i < Tmo; i++) begin
            @(negedge clk);
            chk("fetch.req", 32'(mem_if.imem_req), 32'd1);
            chk("fetch.irwe", 32'(ir_we), 32'd0);
            adv();
        end
        if (fwait >= Tmo) begin
            m_halt  = 1'b1;
            m_cause = 3'd1;
            check_state("imem_tmo");
            return;
        end
        mem_if.imem_ack = 1'b1;
        @(negedge clk);
        chk("ack.req", 32'(mem_if.imem_req), 32'd1);
        chk("ack.irwe", 32'(ir_we), 32'd1);
        chk("ack.pc", pc, m_pc);
        chk("ack.instret", instret, m_instret);
        adv();
        mem_if.imem_ack = 1'b0;
        set_flags(k, ill);
        next_pc = npc;
        @(negedge clk);
        chk("dec.strobes", 32'({mem_if.imem_req, ir_we, mem_if.dmem_req, rf_we}), 32'd0);
        adv();
        if (ill) begin
            m_halt  = 1'b1;
            m_cause = 3'd2;
            check_state("illegal");
            return;
        end
        @(negedge clk);
        chk("exec.op_sel", 32'(op_sel), 32'(exp_op_sel(k)));
        chk("exec.strobes", 32'({mem_if.imem_req, mem_if.dmem_req, rf_we}), 32'd0);
        adv();
        if (mem_op) begin
            for (int i = 0; i < mwait && i < Tmo; i++) begin
                @(negedge clk);
                chk("mem.req", 32'(mem_if.dmem_req), 32'd1);
                chk("mem.we", 32'(mem_if.dmem_we), 32'(k == KStore));
                chk("mem.op_sel", 32'(op_sel), 32'(exp_op_sel(k)));
                chk("mem.rf_we", 32'(rf_we), 32'd0);
                adv();
            end
            if (mwait >= Tmo) begin
                m_halt  = 1'b1;
                m_cause = 3'd3;
                check_state("dmem_tmo");
                return;
            end
            mem_if.dmem_ack = 1'b1;
            @(negedge clk);
            chk("mack.req", 32'(mem_if.dmem_req), 32'd1);
            chk("mack.we", 32'(mem_if.dmem_we), 32'(k == KStore));
            chk("mack.rf_we", 32'(rf_we), 32'd0);
            adv();
            mem_if.dmem_ack = 1'b0;
        end
        if (k != KStore) begin
            @(negedge clk);
            chk("wb.rf_we", 32'(rf_we), 32'(aligned && k != KBr));
            chk("wb.wb_sel", 32'(wb_sel), 32'(k == KLoad));
            chk("wb.op_sel", 32'(op_sel), 32'(exp_op_sel(k)));
            chk("wb.dmem_req", 32'(mem_if.dmem_req), 32'd0);
            adv();
        end
        if (aligned) begin
            m_pc      = npc;
            m_instret = m_instret + 32'd1;
        end else begin
            m_halt  = 1'b1;
            m_cause = 3'd4;
        end
        clear_flags();
        check_state("retire");
    endtask

    // In TRAP, throw acks and new targets at the DUT; nothing may move.
    task automatic trap_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            mem_if.imem_ack = 1'($urandom_range(0, 1));
            mem_if.dmem_ack = 1'($urandom_range(0, 1));
            next_pc = $urandom;
            @(negedge clk);
            chk("trap.halted", 32'(halted), 32'd1);
            chk("trap.strobes", 32'({mem_if.imem_req, ir_we, mem_if.dmem_req, rf_we}), 32'd0);
            chk("trap.pc", pc, m_pc);
            chk("trap.instret", instret, m_instret);
            chk("trap.cause", 32'(cause), 32'(m_cause));
            adv();
        end
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kk;
        logic [31:0] rnd;
        logic [31:0] npc;
        logic        ill;

        rst_n = 1'b1;
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        next_pc = '0;
        clear_flags();
        #2;
        do_reset();

        // Reg-reg add, load, jal, store, branch.
        run_instr(KAlu, 0, 0, 32'h104, 1'b0);
        run_instr(KLoad, 0, 3, 32'h108, 1'b0);
        run_instr(KJal, 0, 0, 32'h200, 1'b0);
        run_instr(KStore, 1, 2, 32'h204, 1'b0);
        run_instr(KBr, 0, 0, 32'h1F8, 1'b0);

        // Illegal instruction, then acks must not disturb the trap.
        run_instr(KAlu, 0, 0, 32'h1FC, 1'b1);
        trap_hold(5);
        do_reset();

        // Fetch timeout, and an ack on the last allowed cycle.
        run_instr(KAlu, Tmo, 0, 32'h104, 1'b0);
        trap_hold(2);
        do_reset();
        run_instr(KAlu, Tmo - 1, 0, 32'h104, 1'b0);

        // Data timeout, and its boundary.
        run_instr(KLoad, 0, Tmo - 1, 32'h108, 1'b0);
        run_instr(KLoad, 0, Tmo, 32'h10C, 1'b0);
        trap_hold(2);
        do_reset();

        // Misaligned jalr and misaligned store retire.
        run_instr(KJalr, 0, 0, 32'h102, 1'b0);
        trap_hold(2);
        do_reset();
        run_instr(KStore, 0, 1, 32'h103, 1'b0);
        trap_hold(2);
        do_reset();

        // Reset while a store waits in MEM.
        run_instr(KAlu, 0, 0, 32'h180, 1'b0);
        mem_if.imem_ack = 1'b1;
        adv();
        mem_if.imem_ack = 1'b0;
        set_flags(KStore, 1'b0);
        next_pc = 32'h300;
        adv();
        adv();
        @(negedge clk);
        chk("midmem.req", 32'(mem_if.dmem_req), 32'd1);
        do_reset();
        check_state("post_rst");
        run_instr(KImm, 0, 0, 32'h104, 1'b0);

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            kk  = int'($urandom_range(0, 8));
            rnd = $urandom;
            npc = {rnd[31:2], 2'b00};
            if ($urandom_range(0, 9) == 0) npc[1:0] = 2'($urandom_range(1, 3));
            ill = ($urandom_range(0, 14) == 0);
            run_instr(kind_e'(kk), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      npc, ill);
            if (m_halt) begin
                trap_hold(2);
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
